// File: rtl/alu_sequencer.sv
// Operation sequencer around one shared 16-bit combinational ALU: single-cycle
// ALU ops, plus an unsigned shift-add multiply that reuses the ALU adder.

module alu_sequencer_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_NOR = 3'b101;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           add_ovf;
  logic           sub_ovf;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    y        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (f)
      F_AND: y = a & b;
      F_OR:  y = a | b;
      F_XOR: y = a ^ b;
      F_NOR: y = ~(a | b);
      F_ADD: begin
        y        = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = add_ovf;
      end
      F_SUB: begin
        y        = diff_ext[WIDTH-1:0];
        carry    = diff_ext[WIDTH];
        overflow = sub_ovf;
      end
      F_SLT: begin
        // Raw sign of a-b, not corrected for overflow.
        y        = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH-1]};
        carry    = diff_ext[WIDTH];
        overflow = sub_ovf;
      end
      default: y = '0;
    endcase
  end

endmodule

module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  // state | meaning
  // IDLE  | waiting for start; done may be high here for one cycle
  // EXEC  | one-cycle ALU op (or illegal op) on captured operands
  // MUL   | WIDTH-cycle shift-add multiply using the ALU adder
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [2:0] F_ADD    = 3'b010;
  localparam logic [2:0] F_UNUSED = 3'b011;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [2:0]       f_q,       f_d;
  logic             ill_q,     ill_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [CNTW-1:0]  cnt_q,     cnt_d;
  logic             csticky_q, csticky_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             carry_q,   carry_d;
  logic             ovf_q,     ovf_d;
  logic             err_q,     err_d;
  logic             done_q,    done_d;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;
  logic             op_illegal;
  logic [WIDTH-1:0] acc_next;
  logic             csticky_next;

  alu_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .f        (alu_f),
    .y        (alu_y),
    .carry    (alu_c),
    .overflow (alu_v)
  );

  // The multiply loop borrows the ALU adder; otherwise the ALU sees captured operands.
  always_comb begin
    alu_a = a_q;
    alu_b = b_q;
    alu_f = f_q;
    if (state_q == ST_MUL) begin
      alu_a = acc_q;
      alu_b = mcand_q;
      alu_f = F_ADD;
    end
  end

  assign op_illegal   = op[3] ? (op != OP_MUL) : (op[2:0] == F_UNUSED);
  assign acc_next     = mplier_q[0] ? alu_y : acc_q;
  assign csticky_next = csticky_q | (mplier_q[0] & alu_c);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    f_d       = f_q;
    ill_d     = ill_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    csticky_d = csticky_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          f_d   = op[2:0];
          ill_d = op_illegal;
          if (op == OP_MUL) begin
            state_d   = ST_MUL;
            acc_d     = '0;
            mcand_d   = a;
            mplier_d  = b;
            cnt_d     = '0;
            csticky_d = 1'b0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (ill_q) begin
          result_d = '0;
          zero_d   = 1'b1;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b1;
        end else begin
          result_d = alu_y;
          zero_d   = (alu_y == '0);
          carry_d  = alu_c;
          ovf_d    = alu_v;
          err_d    = 1'b0;
        end
      end

      ST_MUL: begin
        acc_d     = acc_next;
        csticky_d = csticky_next;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = acc_next;
          zero_d   = (acc_next == '0);
          carry_d  = csticky_next;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f_q       <= '0;
      ill_q     <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      csticky_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f_q       <= f_d;
      ill_q     <= ill_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      csticky_q <= csticky_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with hand-computed expected values.

module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        err;

  int n_vec;
  int n_mis;

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an op (edge 0), then count edges until done; optionally inject a
  // stray start while busy at a given loop iteration.
  task automatic run_op(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                        input int inj_at, output int lat);
    op = o; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; op = 4'b0000;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == inj_at) begin
        start = 1'b1; op = 4'b0010; a = 16'h1111; b = 16'h2222;
      end
      tick();
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] r, input logic z,
                           input logic c, input logic v, input logic e);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"}, zero, z);
    chk({tag, ".carry"}, carry, c);
    chk({tag, ".ovf"}, overflow, v);
    chk({tag, ".err"}, err, e);
  endtask

  initial begin
    int lat;
    n_vec = 0; n_mis = 0;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.result", result, 16'h0000);
    chk("rst.flags", {zero, carry, overflow, err}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // ADD with signed overflow
    run_op(4'b0010, 16'h7FFF, 16'h0001, -1, lat);
    chk("add.lat", lat, 1);
    chk_flags("add", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("add.done_one", done, 1'b0);
    chk("add.hold", result, 16'h8000);

    // SUB then SLT issued in the done cycle
    run_op(4'b0110, 16'h0005, 16'h0005, -1, lat);
    chk("sub.lat", lat, 1);
    chk_flags("sub", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(4'b0111, 16'hFFFF, 16'h0001, -1, lat);
    chk("slt.lat", lat, 1);
    chk_flags("slt", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Logic ops and a sub with borrow
    run_op(4'b0000, 16'hF0F0, 16'h3C3C, -1, lat);
    chk_flags("and", 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'b0101, 16'hF0F0, 16'h0F0F, -1, lat);
    chk_flags("nor", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(4'b0110, 16'h0000, 16'h0001, -1, lat);
    chk_flags("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // MUL 3*5 with a stray start injected while busy
    run_op(4'b1000, 16'h0003, 16'h0005, 4, lat);
    chk("mul1.lat", lat, 16);
    chk_flags("mul1", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mul1.no_extra", {busy, done}, 2'b00);
    chk("mul1.hold", result, 16'h000F);

    run_op(4'b1000, 16'h0100, 16'h0100, -1, lat);
    chk("mul2.lat", lat, 16);
    chk_flags("mul2", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    run_op(4'b1000, 16'hFFFF, 16'h0003, -1, lat);
    chk("mul3.lat", lat, 16);
    chk_flags("mul3", 16'hFFFD, 1'b0, 1'b1, 1'b0, 1'b0);

    // Illegal codes
    run_op(4'b0011, 16'h1234, 16'h5678, -1, lat);
    chk("ill3.lat", lat, 1);
    chk_flags("ill3", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(4'b0010, 16'h0001, 16'h0001, -1, lat);
    chk_flags("add_clr_err", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'b1100, 16'hFFFF, 16'hFFFF, -1, lat);
    chk("illc.lat", lat, 1);
    chk_flags("illc", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // Give result a nonzero value, then reset mid-MUL
    run_op(4'b0010, 16'h0010, 16'h0001, -1, lat);
    chk("pre_rst.result", result, 16'h0011);
    op = 4'b1000; a = 16'h0007; b = 16'h0009; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid.busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.busy", busy, 1'b0);
    chk("arst.result", result, 16'h0000);
    chk("arst.done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) lat++;
    end
    chk("arst.no_done", lat, 0);

    run_op(4'b0010, 16'h0002, 16'h0003, -1, lat);
    chk("post.lat", lat, 1);
    chk_flags("post_add", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
